fetch_queue: RTL and testbench

- Instruction fetch stage with a prefetch buffer, sitting directly upstream of decode/execute in the MIPS datapath.
- Issues word fetches to a byte-addressed instruction memory that takes one or more cycles to answer, with one request outstanding at a time.
- Buffers returned instructions, tagged with their PC, in an in-order queue and presents them to decode with a valid/ready handshake.
- A redirect from branch resolution flushes the queue and discards any stale in-flight response.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue: MIPS instruction fetch stage feeding an in-order prefetch queue
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];

  logic            push;
  logic            pop;

  always_comb begin
    inst_valid  = (count_q != '0);
    inst_data   = inst_valid ? data_q[rd_ptr_q] : 32'h0;
    inst_pc     = inst_valid ? pc_q[rd_ptr_q]   : 32'h0;
    queue_count = count_q;
    mem_addr    = fetch_pc_q;

    // A request is only issued when its response is guaranteed a free slot.
    mem_req = !reset && (state_q == S_FETCH) && (count_q != C_DEPTH) && !redirect_valid;
    push    = (state_q == S_WAIT) && mem_ready && !redirect_valid;
    pop     = inst_valid && inst_ready && !redirect_valid;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_FETCH: begin
        if (mem_req) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready)           state_d = S_FETCH;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (mem_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: contents are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue: randomized bench for fetch_queue against a queue-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [$clog2(DEPTH):0] queue_count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected fetch address, one outstanding-request flag,
  // a stale marker for redirected requests, and the instruction queue.
  logic [63:0] mq[$];
  logic [31:0] m_fpc, m_reqpc;
  bit          m_out, m_stale;

  // Instruction memory environment
  bit          pend;
  logic [31:0] pend_addr;
  int          resp_cyc;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  bit          spur_en = 1'b0;

  // Observed outputs, sampled 1 time unit after the falling edge
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_data, obs_cnt;
  bit          saw_pc8;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0043_1020;
      32'h4:   return 32'h0250_8820;
      32'h8:   return 32'h0000_0000;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc   = RESET_PC;
    m_reqpc = 32'h0;
    m_out   = 1'b0;
    m_stale = 1'b0;
    pend    = 1'b0;
  endtask

  task automatic step(input bit rst_i, input bit rv, input logic [31:0] rpc, input bit ir);
    bit          exp_req, real_resp;
    logic [63:0] head;
    @(negedge clk);
    reset          = rst_i;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = ir;
    real_resp      = pend && (cyc == resp_cyc);
    mem_ready      = real_resp || (!pend && spur_en && ($urandom_range(0, 7) == 0));
    mem_rdata      = real_resp ? word_at(pend_addr) : $urandom;
    #1;
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    obs_data  = inst_data;
    obs_cnt   = 32'(queue_count);
    if (inst_valid && inst_pc == 32'h8) saw_pc8 = 1'b1;

    exp_req = !rst_i && !m_out && (mq.size() < DEPTH) && !rv;
    head    = (mq.size() != 0) ? mq[0] : 64'h0;
    chk("mem_req", 32'(obs_req), 32'(exp_req));
    if (exp_req) chk("mem_addr", obs_addr, m_fpc);
    chk("inst_valid", 32'(obs_valid), 32'(mq.size() != 0));
    chk("queue_count", obs_cnt, 32'(mq.size()));
    chk("inst_pc", obs_pc, head[63:32]);
    chk("inst_data", obs_data, head[31:0]);

    if (rst_i) pend = 1'b0;
    else begin
      if (real_resp) pend = 1'b0;
      if (mem_req) begin
        pend      = 1'b1;
        pend_addr = mem_addr;
        resp_cyc  = cyc + $urandom_range(lat_min, lat_max);
      end
    end

    if (rst_i) model_reset();
    else begin
      if (rv) begin
        mq.delete();
        m_fpc = rpc & 32'hFFFF_FFFC;
      end else if (mq.size() != 0 && ir) begin
        void'(mq.pop_front());
      end
      if (m_out && mem_ready) begin
        if (!rv && !m_stale) mq.push_back({m_reqpc, mem_rdata});
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else if (m_out && rv) begin
        m_stale = 1'b1;
      end
      if (exp_req) begin
        m_out   = 1'b1;
        m_reqpc = m_fpc;
        m_fpc   = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nreq;
    bit  found;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state and in-order fetch with a 1-cycle memory
    lat_min = 1; lat_max = 1;
    do_reset();
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_count", obs_cnt, 32'd0);
    chk("rst_req", 32'(obs_req), 32'd0);
    step(0, 0, 0, 1); chk("t1_req0", {obs_req, obs_addr[30:0]}, 32'h8000_0000);
    step(0, 0, 0, 1); chk("t1_idle", 32'(obs_req), 32'd0);
    step(0, 0, 0, 1); chk("t1_req4", obs_addr, 32'h4);
    chk("t1_pc0", obs_pc, 32'h0); chk("t1_d0", obs_data, 32'h0043_1020);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("t1_pc4", obs_pc, 32'h4); chk("t1_d4", obs_data, 32'h0250_8820);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("t1_pc8", {31'(obs_pc), obs_valid}, {31'h8, 1'b1});

    // Fill to DEPTH with decode stalled, then drain
    do_reset();
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      if (obs_req) nreq++;
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_full", obs_cnt, 32'd4);
    chk("t2_hold", 32'(obs_req), 32'd0);
    step(0, 0, 0, 1); chk("t2_pop0", obs_pc, 32'h0);
    step(0, 0, 0, 1); chk("t2_pop4", obs_pc, 32'h4); chk("t2_next", obs_addr, 32'h10);
    chk("t2_nreq1", 32'(obs_req), 32'd1);
    step(0, 0, 0, 1); chk("t2_pop8", obs_pc, 32'h8);
    step(0, 0, 0, 1); chk("t2_popC", obs_pc, 32'hC);

    // Redirect while waiting on 0x8, response three cycles after the request
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(0, 0, 0, 1);
      if (obs_req && obs_addr == 32'h8) found = 1'b1;
    end
    chk("t3_find8", 32'(found), 32'd1);
    saw_pc8 = 1'b0;
    step(0, 1, 32'h40, 1);
    step(0, 0, 0, 1); chk("t3_flush", obs_cnt, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, 0, 1);
      if (obs_req) found = 1'b1;
    end
    chk("t3_reqseen", 32'(found), 32'd1);
    chk("t3_addr", obs_addr, 32'h40);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("t3_no_pc8", 32'(saw_pc8), 32'd0);

    // Redirect + mem_ready + inst_ready together with two entries queued
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("t4_cnt2", obs_cnt, 32'd2); chk("t4_req8", obs_addr, 32'h8);
    step(0, 1, 32'h80, 1);
    chk("t4_rdy", 32'(mem_ready), 32'd1);
    step(0, 0, 0, 0);
    chk("t4_flush", obs_cnt, 32'd0);
    chk("t4_target", {obs_req, obs_addr[30:0]}, 32'h8000_0080);

    // Unaligned redirect target
    do_reset();
    step(0, 1, 32'h43, 1);
    step(0, 0, 0, 1); chk("t5_addr40", obs_addr, 32'h40);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("t5_addr44", obs_addr, 32'h44);
    chk("t5_pc40", obs_pc, 32'h40); chk("t5_d40", obs_data, word_at(32'h40));

    // Reset while waiting with two entries queued
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_valid", 32'(obs_valid), 32'd0);
    chk("t6_count", obs_cnt, 32'd0);
    chk("t6_addr", obs_addr, RESET_PC);

    // Simultaneous push and pop at count 2
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t6_pp_cnt", obs_cnt, 32'd2); chk("t6_pp_pc", obs_pc, 32'h4);

    // Randomized traffic
    spur_en = 1'b1;
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int ir_pct;
      ir_pct = 20 + blk * 15;
      for (int i = 0; i < 500; i++) begin
        bit          r_rst, r_rv, r_ir;
        logic [31:0] r_pc;
        r_rst = ($urandom_range(0, 299) == 0);
        r_rv  = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 3))
          0:       r_pc = $urandom;
          1:       r_pc = 32'hFFFF_FFF4;
          default: r_pc = {24'h0, 8'($urandom)};
        endcase
        r_ir = ($urandom_range(0, 99) < ir_pct);
        step(r_rst, r_rv, r_pc, r_ir);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
